// File: rtl/alu_8_issue_unit_if.sv
// Request/response channel between a client and the ALU_8 issue unit.
// The client drives the master side, the issue unit sits on the slave side.
interface alu_8_issue_unit_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_op;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_negative;
    logic       rsp_overflow;
    logic       rsp_illegal;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_negative,
               rsp_overflow, rsp_illegal
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_negative,
               rsp_overflow, rsp_illegal
    );
endinterface

// File: rtl/alu_8_issue_unit.sv
// Registered front end for the combinational ALU_8: accepts one op, holds the
// operands for one execute cycle, captures result/flags and presents a response.
module alu_8_issue_unit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_8_issue_unit_if.slave    bus,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_op,
    input  logic [7:0]           alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_negative,
    input  logic                 alu_overflow,
    output logic                 sticky_ovf,
    input  logic                 sticky_clr,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       op_legal;

    always_comb begin
        op_legal = 1'b1;
        case (bus.req_op)
            4'b0011, 4'b0100, 4'b1110, 4'b1111: op_legal = 1'b0;
            default:                            op_legal = 1'b1;
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_op           <= '0;
            bus.rsp_result   <= '0;
            bus.rsp_zero     <= 1'b0;
            bus.rsp_negative <= 1'b0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_illegal  <= 1'b0;
            sticky_ovf       <= 1'b0;
            op_count         <= '0;
        end else begin
            // A capture with overflow beats a simultaneous clear.
            if (state == EXEC && alu_overflow)
                sticky_ovf <= 1'b1;
            else if (sticky_clr)
                sticky_ovf <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (op_legal) begin
                            alu_a  <= bus.req_a;
                            alu_b  <= bus.req_b;
                            alu_op <= bus.req_op;
                            state  <= EXEC;
                        end else begin
                            bus.rsp_result   <= '0;
                            bus.rsp_zero     <= 1'b1;
                            bus.rsp_negative <= 1'b0;
                            bus.rsp_overflow <= 1'b0;
                            bus.rsp_illegal  <= 1'b1;
                            state            <= RESP;
                        end
                    end
                end
                EXEC: begin
                    bus.rsp_result   <= alu_result;
                    bus.rsp_zero     <= alu_zero;
                    bus.rsp_negative <= alu_negative;
                    bus.rsp_overflow <= alu_overflow;
                    bus.rsp_illegal  <= 1'b0;
                    state            <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        op_count <= op_count + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_8_issue_unit.sv
// Directed bench for alu_8_issue_unit with a small behavioural ALU_8 stand-in.
module tb_alu_8_issue_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero, alu_negative, alu_overflow;
    logic       sticky_ovf, sticky_clr;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_8_issue_unit_if bus ();

    alu_8_issue_unit #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .sticky_ovf   (sticky_ovf),
        .sticky_clr   (sticky_clr),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    // Stand-in ALU_8: add, B-A, AND, OR; other codes give 0.
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'b0000: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            4'b0001: begin
                alu_result   = alu_b - alu_a;
                alu_overflow = (alu_b[7] != alu_a[7]) && (alu_result[7] != alu_b[7]);
            end
            4'b0010: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
        alu_zero     = (alu_result == 8'd0);
        alu_negative = alu_result[7];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns #1 after the edge that accepts it.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL issue_wait: req_ready got %0d expected 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: req_ready/rsp_valid got %b%b expected 10", bus.req_ready, bus.rsp_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 20'd0 || op_count !== 8'd0 || sticky_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: alu=%h/%h/%h cnt=%0d sticky=%b expected zeros", alu_a, alu_b, alu_op, op_count, sticky_ovf);
        end
        checks++;
        if ({bus.rsp_result, bus.rsp_zero, bus.rsp_negative, bus.rsp_overflow, bus.rsp_illegal} !== 12'd0) begin
            errors++;
            $display("FAIL reset_rsp: result=%0d flags=%b%b%b%b expected 0 0000", bus.rsp_result,
                     bus.rsp_zero, bus.rsp_negative, bus.rsp_overflow, bus.rsp_illegal);
        end
    endtask

    task automatic test_add();
        issue(8'd15, 8'd10, 4'b0000);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: rsp_valid/req_ready got %b%b expected 00", bus.rsp_valid, bus.req_ready);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'd25 || bus.rsp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp: valid=%b result=%0d illegal=%b expected 1 25 0", bus.rsp_valid, bus.rsp_result, bus.rsp_illegal);
        end
        checks++;
        if ({bus.rsp_zero, bus.rsp_negative, bus.rsp_overflow} !== 3'b000) begin
            errors++;
            $display("FAIL add_flags: got %b%b%b expected 000", bus.rsp_zero, bus.rsp_negative, bus.rsp_overflow);
        end
        handshake();
        checks++;
        if (op_count !== 8'd1 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_count: cnt=%0d valid=%b ready=%b expected 1 0 1", op_count, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_overflow();
        issue(8'd100, 8'd50, 4'b0000);
        tick();
        checks++;
        if (bus.rsp_result !== 8'd150 || bus.rsp_negative !== 1'b1 || bus.rsp_overflow !== 1'b1 || bus.rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL ovf_rsp: result=%0d z/n/o=%b%b%b expected 150 011", bus.rsp_result,
                     bus.rsp_zero, bus.rsp_negative, bus.rsp_overflow);
        end
        checks++;
        if (sticky_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", sticky_ovf);
        end
        handshake();
        issue(8'd20, 8'd20, 4'b0001);
        tick();
        checks++;
        if (bus.rsp_zero !== 1'b1 || bus.rsp_result !== 8'd0 || sticky_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: zero=%b result=%0d sticky=%b expected 1 0 1", bus.rsp_zero, bus.rsp_result, sticky_ovf);
        end
        handshake();
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        checks++;
        if (sticky_ovf !== 1'b0 || op_count !== 8'd3) begin
            errors++;
            $display("FAIL sticky_clr: sticky=%b cnt=%0d expected 0 3", sticky_ovf, op_count);
        end
    endtask

    task automatic test_illegal();
        issue(8'd5, 8'd5, 4'b1110);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_illegal !== 1'b1) begin
            errors++;
            $display("FAIL ill_latency: valid=%b illegal=%b expected 1 1", bus.rsp_valid, bus.rsp_illegal);
        end
        checks++;
        if (bus.rsp_result !== 8'd0 || {bus.rsp_zero, bus.rsp_negative, bus.rsp_overflow} !== 3'b100) begin
            errors++;
            $display("FAIL ill_rsp: result=%0d z/n/o=%b%b%b expected 0 100", bus.rsp_result,
                     bus.rsp_zero, bus.rsp_negative, bus.rsp_overflow);
        end
        checks++;
        if (alu_op !== 4'b0001 || alu_a !== 8'd20 || alu_b !== 8'd20 || sticky_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ill_alu: op=%b a=%0d b=%0d sticky=%b expected 0001 20 20 0", alu_op, alu_a, alu_b, sticky_ovf);
        end
        handshake();
        checks++;
        if (op_count !== 8'd4) begin
            errors++;
            $display("FAIL ill_count: got %0d expected 4", op_count);
        end
    endtask

    task automatic test_backpressure();
        issue(8'd255, 8'd0, 4'b0010);
        tick();
        bus.req_valid = 1'b1;
        bus.req_a     = 8'd7;
        bus.req_b     = 8'd3;
        bus.req_op    = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'd0 || bus.rsp_zero !== 1'b1 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b result=%0d zero=%b ready=%b expected 1 0 1 0", i,
                         bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.req_ready);
            end
            tick();
        end
        handshake();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || alu_a !== 8'd255) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b alu_a=%0d expected 1 0 255", bus.req_ready, bus.rsp_valid, alu_a);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0 || alu_a !== 8'd7 || alu_b !== 8'd3) begin
            errors++;
            $display("FAIL bp_accept: ready=%b alu_a=%0d alu_b=%0d expected 0 7 3", bus.req_ready, alu_a, alu_b);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'd10) begin
            errors++;
            $display("FAIL bp_next: valid=%b result=%0d expected 1 10", bus.rsp_valid, bus.rsp_result);
        end
        handshake();
    endtask

    task automatic test_reset_exec();
        issue(8'd77, 8'd77, 4'b0101);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || op_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_exec: valid=%b ready=%b cnt=%0d expected 0 1 0", bus.rsp_valid, bus.req_ready, op_count);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 20'd0) begin
            errors++;
            $display("FAIL rst_alu: a=%0d b=%0d op=%b expected 0 0 0000", alu_a, alu_b, alu_op);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_norsp%0d: valid got %b expected 0", i, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_same_edge();
        issue(8'd100, 8'd50, 4'b0000);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        checks++;
        if (sticky_ovf !== 1'b1 || bus.rsp_overflow !== 1'b1) begin
            errors++;
            $display("FAIL same_edge: sticky=%b ovf=%b expected 1 1", sticky_ovf, bus.rsp_overflow);
        end
        handshake();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            issue(8'd1, 8'd2, 4'b0000);
            tick();
            handshake();
            if (i == 254) begin
                checks++;
                if (op_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_max: got %0d expected 255", op_count);
                end
            end
        end
        checks++;
        if (op_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: got %0d expected 0", op_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        sticky_clr    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_overflow();
        test_illegal();
        test_backpressure();
        test_reset_exec();
        test_same_edge();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_8_issue_unit.md
Name: alu_8_issue_unit

Overview:
Sequential front end that owns the operand/opcode interface of the combinational ALU_8. It accepts one operation per request over a valid/ready channel, drives A/B/AluOp into ALU_8 from registers, captures Result and the Zero/Negative/Overflow flags, and returns them over a valid/ready response channel. It also keeps a sticky overflow flag and a completed-operation counter for status reads.

Parameters:
CNT_W, 8, width of the completed-operation counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_a  input  8  operand A
req_b  input  8  operand B
req_op  input  4  AluOp code
alu_a  output  8  registered operand A to ALU_8
alu_b  output  8  registered operand B to ALU_8
alu_op  output  4  registered AluOp to ALU_8
alu_result  input  8  ALU_8 Result
alu_zero  input  1  ALU_8 Zero
alu_negative  input  1  ALU_8 Negative
alu_overflow  input  1  ALU_8 Overflow
rsp_valid  output  1  response held
rsp_ready  input  1  consumer accepts response
rsp_result  output  8  captured result
rsp_zero  output  1  captured Zero
rsp_negative  output  1  captured Negative
rsp_overflow  output  1  captured Overflow
rsp_illegal  output  1  request carried an unsupported opcode
sticky_ovf  output  1  set by any response with overflow, held until clear
sticky_clr  input  1  clears sticky_ovf
op_count  output  CNT_W  number of responses consumed

Behaviour:
- Reset (rst=1 at edge): state IDLE; req_ready=1; rsp_valid=0; alu_a/alu_b/alu_op=0; rsp_result=0; all rsp flags=0; sticky_ovf=0; op_count=0. Reset overrides everything, including a request or an operation in flight: the in-flight op is discarded and no response is produced.
- Legal opcodes: 0000, 0001, 0010, 0101, 0110, 0111, 1000 to 1101. Illegal opcodes: 0011, 0100, 1110, 1111.
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1:
  - legal op: load alu_a/alu_b/alu_op from the request; go to EXEC.
  - illegal op: alu_* unchanged; rsp_result=0, rsp_zero=1, rsp_negative=0, rsp_overflow=0, rsp_illegal=1; go to RESP directly.
- EXEC: req_ready=0. ALU_8 settles combinationally during this cycle. At the closing edge, capture alu_result and the three flags into the rsp_* registers, set rsp_illegal=0, and go to RESP. EXEC always lasts exactly 1 cycle.
- RESP: rsp_valid=1, req_ready=0.
  - On an edge with rsp_ready=1: go to IDLE and increment op_count (wraps to 0 after 2^CNT_W-1).
  - rsp_ready=0: hold all rsp_* outputs stable indefinitely.
- Latency:
  - legal op accepted at edge N: rsp_valid=1 from edge N+2.
  - illegal op: rsp_valid=1 from edge N+1.
  - peak throughput: 1 op per 3 cycles.
- alu_* outputs retain their last legal values outside EXEC. No combinational path runs from req_* to alu_*.
- sticky_ovf:
  - set on the EXEC capture edge when alu_overflow=1.
  - cleared on any edge with sticky_clr=1.
  - same-edge set and clear: set wins.
  - illegal ops never set it.
- Flags are passed through unmodified. ALU semantics (e.g. 0001 = B minus A, shifts by 1) belong to ALU_8, not this unit.
- A response's rsp_* values change only at the EXEC capture edge or the IDLE illegal-op edge. They are never changed during RESP.

Test Plan:
- A=15, B=10, op=0000 accepted at edge N -> rsp_valid at N+2. rsp_result=25, Z/N/O=0/0/0, rsp_illegal=0. op_count=1 after rsp_ready handshake.
- A=100, B=50, op=0000 -> rsp_result=150, rsp_negative=1, rsp_overflow=1, sticky_ovf=1. Next op 20-20 (op 0001) -> rsp_zero=1, sticky_ovf remains 1. Pulse sticky_clr -> sticky_ovf=0.
- op=1110, A=5, B=5 -> rsp_valid after 1 edge. rsp_illegal=1, rsp_result=0, rsp_zero=1. alu_op keeps the previous legal value. sticky_ovf unchanged.
- Backpressure: A=255, op=0010 with rsp_ready=0 for 5 cycles and req_valid held high with a new request -> rsp_result=0 and rsp_zero=1 stable for all 5 cycles, req_ready=0 throughout. New request accepted on the cycle after rsp_ready=1.
- Assert rst during EXEC for A=77, B=77, op=0101 -> next cycle rsp_valid=0, req_ready=1, alu_*=0, op_count=0. No response is ever presented for the aborted op.
- Same-edge sticky_clr=1 and an overflowing capture (100+50) -> sticky_ovf=1. Run 256 ops with CNT_W=8 -> op_count wraps to 0.
